rv32i_decode: RTL

RV32I_DECODE -- requirements
Module: rv32i_decode

---
 rtl/rv32i_decode.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_decode.sv
// rv32i_decode: single registered decode stage for RV32I with a valid/ready handshake.
// Define ILLEGAL_INSN_DETECT_EN to enable illegal-instruction detection on o_illegal.
module rv32i_decode #(
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_insn,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_imm,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_src_imm,
  output logic        o_reg_wr,
  output logic        o_branch,
  output logic        o_jump,
  output logic        o_load,
  output logic        o_store,
  output logic [2:0]  o_funct3,
  output logic        o_illegal
);

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_wr;
    logic        branch;
    logic        jump;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic        illegal;
  } dec_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Unknown opcodes fall through with the all-zero NOP field set (ADDI x0,x0,0).
  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic [2:0] f3;
`ifdef ILLEGAL_INSN_DETECT_EN
    logic [6:0] f7;
    logic       bad;
`endif
    f3 = w[14:12];
    d = '0;
    d.alu_src_imm = 1'b1;
    case (w[6:0])
      OPC_OP: begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7]; d.funct3 = f3;
        d.alu_op = alu_from_f3(f3, w[30]);
        d.alu_src_imm = 1'b0; d.reg_wr = 1'b1;
      end
      OPC_OP_IMM: begin
        d.rs1 = w[19:15]; d.rd = w[11:7]; d.funct3 = f3;
        d.imm = {{20{w[31]}}, w[31:20]};
        d.alu_op = alu_from_f3(f3, (f3 == 3'b101) && w[30]);
        d.reg_wr = 1'b1;
      end
      OPC_LOAD: begin
        d.rs1 = w[19:15]; d.rd = w[11:7]; d.funct3 = f3;
        d.imm = {{20{w[31]}}, w[31:20]};
        d.load = 1'b1; d.reg_wr = 1'b1;
      end
      OPC_STORE: begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct3 = f3;
        d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        d.store = 1'b1;
      end
      OPC_BRANCH: begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct3 = f3;
        d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        d.branch = 1'b1; d.alu_src_imm = 1'b0;
      end
      OPC_JAL: begin
        d.rd = w[11:7]; d.funct3 = f3;
        d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        d.jump = 1'b1; d.reg_wr = 1'b1;
      end
      OPC_JALR: begin
        d.rs1 = w[19:15]; d.rd = w[11:7]; d.funct3 = f3;
        d.imm = {{20{w[31]}}, w[31:20]};
        d.jump = 1'b1; d.reg_wr = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        d.rd = w[11:7]; d.funct3 = f3;
        d.imm = {w[31:12], 12'b0};
        d.reg_wr = 1'b1;
      end
      default: ;
    endcase
    if (d.rd == 5'd0) d.reg_wr = 1'b0;
`ifdef ILLEGAL_INSN_DETECT_EN
    f7 = w[31:25];
    case (w[6:0])
      OPC_OP:     bad = ((f7 != 7'h00) && (f7 != 7'h20)) ||
                        ((f7 == 7'h20) && (f3 != 3'b000) && (f3 != 3'b101));
      OPC_OP_IMM: bad = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                        ((f3 == 3'b101) && !w[30] && (f7 != 7'h00)) ||
                        ((f3 == 3'b101) &&  w[30] && (f7 != 7'h20));
      OPC_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011);
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: bad = 1'b0;
      default:    bad = 1'b1;
    endcase
    if (bad) begin
      d.illegal = 1'b1;
      d.reg_wr = 1'b0; d.branch = 1'b0; d.jump = 1'b0; d.load = 1'b0; d.store = 1'b0;
    end
`endif
    return d;
  endfunction

  localparam dec_t NOP_DEC = decode(NOP_INSN);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  dec_t        dec_q, dec_d;
  logic        accept;

  always_comb begin
    o_ready = !valid_q || i_ready;
    accept  = i_valid && o_ready;
    valid_d = valid_q;
    pc_d    = pc_q;
    dec_d   = dec_q;
    if (i_flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
      dec_d   = NOP_DEC;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = i_pc;
      dec_d   = decode(i_insn);
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output stage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      dec_q   <= NOP_DEC;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      dec_q   <= dec_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_pc          = pc_q;
  assign o_rs1_addr    = dec_q.rs1;
  assign o_rs2_addr    = dec_q.rs2;
  assign o_rd_addr     = dec_q.rd;
  assign o_imm         = dec_q.imm;
  assign o_alu_op      = dec_q.alu_op;
  assign o_alu_src_imm = dec_q.alu_src_imm;
  assign o_reg_wr      = dec_q.reg_wr;
  assign o_branch      = dec_q.branch;
  assign o_jump        = dec_q.jump;
  assign o_load        = dec_q.load;
  assign o_store       = dec_q.store;
  assign o_funct3      = dec_q.funct3;
  assign o_illegal     = dec_q.illegal;

endmodule
